// File: rtl/adder_pipe_n_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
// The slave side is the adder; the master side sources operands and sinks results.
interface adder_pipe_n_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/adder_pipe_n.sv
// Pipelined two's-complement adder/subtractor: an operand capture register followed by
// STAGES carry-chain slices, with a global stall driven by output backpressure.
module adder_pipe_n #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic          clk,
    input  logic          reset,
    adder_pipe_n_if.slave bus
);
    localparam int unsigned SLICE = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

    // In-flight token: effective operands (B already inverted for subtract),
    // partial result with the lower slices resolved, and the carry into the next slice.
    typedef struct packed {
        logic             vld;
        logic             c;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
    } tok_t;

    typedef struct packed {
        logic             vld;
        logic             c;
        logic             ovf;
        logic [WIDTH-1:0] s;
    } res_t;

    tok_t           tok_q [STAGES];
    tok_t           tok_d [STAGES];
    res_t           res_q;
    res_t           res_d;
    logic [SLICE:0] last_slice;
    logic           stall;

    // Resolve slice k of the carry chain; everything else rides along untouched.
    function automatic tok_t add_slice(input tok_t t, input int unsigned k);
        tok_t           r;
        logic [SLICE:0] ss;
        r  = t;
        ss = {1'b0, t.a[k*SLICE +: SLICE]} + {1'b0, t.b[k*SLICE +: SLICE]}
           + {{SLICE{1'b0}}, t.c};
        r.s[k*SLICE +: SLICE] = ss[SLICE-1:0];
        r.c = ss[SLICE];
        return r;
    endfunction

    assign stall        = res_q.vld && !bus.out_ready;
    assign bus.in_ready = !stall;

    always_comb begin
        tok_d      = '{default: '0};
        res_d      = '0;
        last_slice = '0;

        tok_d[0].vld = bus.in_valid;
        tok_d[0].a   = bus.a;
        tok_d[0].b   = bus.sub ? ~bus.b : bus.b;
        tok_d[0].c   = bus.sub ? 1'b1   : bus.cin;

        for (int unsigned k = 0; k + 1 < STAGES; k++) begin
            tok_d[k+1] = add_slice(tok_q[k], k);
        end

        // Final slice also produces the flags.
        last_slice = {1'b0, tok_q[LAST].a[LAST*SLICE +: SLICE]}
                   + {1'b0, tok_q[LAST].b[LAST*SLICE +: SLICE]}
                   + {{SLICE{1'b0}}, tok_q[LAST].c};
        res_d.vld  = tok_q[LAST].vld;
        res_d.s    = tok_q[LAST].s;
        res_d.s[LAST*SLICE +: SLICE] = last_slice[SLICE-1:0];
        res_d.c    = last_slice[SLICE];
        res_d.ovf  = (tok_q[LAST].a[WIDTH-1] == tok_q[LAST].b[WIDTH-1])
                  && (res_d.s[WIDTH-1] != tok_q[LAST].a[WIDTH-1]);
    end

    // Valid bits always advance; payloads load only behind a valid token so bubbles
    // leave the previous result on sum/cout/ovf.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                tok_q[k] <= '0;
            end
            res_q <= '0;
        end else if (!stall) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                tok_q[k].vld <= tok_d[k].vld;
                if (tok_d[k].vld) begin
                    tok_q[k] <= tok_d[k];
                end
            end
            res_q.vld <= res_d.vld;
            if (res_d.vld) begin
                res_q <= res_d;
            end
        end
    end

    assign bus.out_valid = res_q.vld;
    assign bus.sum       = res_q.s;
    assign bus.cout      = res_q.c;
    assign bus.ovf       = res_q.ovf;
endmodule

// File: doc/adder_pipe_n.md
Name: adder_pipe_n

Overview:
Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes on both sides. It generalises the team's fixed 4-bit registered adder in three ways:
- configurable operand width
- carry chain split across a configurable number of pipeline stages
- add/sub mode plus carry-out and signed-overflow flags

It sits between the operand-sourcing logic and any consumer that can apply backpressure.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages; each stage resolves SLICE = WIDTH/STAGES bits of the carry chain.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operand set on a/b/cin/sub is valid
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in; used in add mode only
sub  input  1  0 = add, 1 = subtract
out_valid  output  1  result on sum/cout/ovf is valid
out_ready  input  1  consumer accepts result this cycle
sum  output  WIDTH  result
cout  output  1  carry-out of the MSB (1 = no borrow in sub mode)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset:
  - Asserting reset (async, any time) clears every stage valid bit and all data registers to 0.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 once reset is low.
  - In-flight operations are discarded; no partial result is ever presented.
- Accept: a transfer into the block occurs on a rising edge with in_valid && in_ready.
- Transfer out: a result leaves on a rising edge with out_valid && out_ready.
- Effective operands:
  - Add mode (sub=0): B' = b, carry-in c0 = cin.
  - Sub mode (sub=1): B' = ~b, c0 = 1; cin is ignored.
- Stage k (k = 0..STAGES-1):
  - Adds slice k of A and B' plus the carry registered by stage k-1 (c0 for stage 0).
  - Registers the slice sum and the carry-out.
  - Lower result slices and the upper, not-yet-added operand slices travel with the token, unmodified, in the same stage register.
  - sub is carried along for flag computation.
- Latency:
  - An operand accepted at edge T produces out_valid=1 after edge T+STAGES, i.e. visible in the cycle after the STAGES-th edge, when not stalled.
  - Throughput is one operation per cycle.
- Flags, computed in the final stage:
  - cout = carry out of bit WIDTH-1.
  - ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
- Stall rule (global, whole-pipeline):
  - stall = out_valid && !out_ready.
  - in_ready = !stall, combinational from out_valid/out_ready.
  - While stall=1, every stage register and all outputs hold their values.
  - Bubbles are not collapsed during a stall.
  - When stall=0, every stage advances by one; a bubble (valid=0) advances like data.
- Output stability: sum/cout/ovf change only when the pipeline advances. They hold steady while out_valid=1 and out_ready=0.
- Simultaneous accept and retire in the same cycle is allowed (stall=0). Both occur, and the occupancy shifts by one.
- Ordering: results retire strictly in acceptance order. No drop, no duplicate.
- Wrap-around: sum is modulo 2^WIDTH; the carry beyond bit WIDTH is reported only on cout.
- Degenerate case STAGES=1: a single registered full-width add with latency 1.
- Idle outputs:
  - out_valid=0 whenever the final stage holds a bubble.
  - sum/cout/ovf then hold their last registered value (don't-care to consumers).

Test Plan (WIDTH=16, STAGES=4, out_ready=1 unless stated):
- Basic add: a=0x1234, b=0x4321, cin=0, sub=0 accepted at edge T -> out_valid high after edge T+4 with sum=0x5555, cout=0, ovf=0; cin=1 on the same operands -> sum=0x5556.
- Carry/overflow:
  - 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
  - 0x00FF+0x0001 -> sum=0x0100 (carry crosses the slice boundary between stages).
- Subtract:
  - 0x0005-0x0007 -> 0xFFFE, cout=0, ovf=0.
  - 0x8000-0x0001 -> 0x7FFF, cout=1, ovf=1.
  - cin=1 with sub=1 does not change either result.
- Backpressure:
  - Stimulus: issue 6 back-to-back ops (a=1..6, b=0x10); hold out_ready=0 for 3 cycles after the first out_valid.
  - in_ready=0 and sum=0x0011 held during the stall.
  - All six results 0x0011..0x0016 retire in order; none lost or duplicated.
  - in_ready returns to 1 in the cycle out_ready rises.
- Bubbles: ops issued with in_valid toggling 1,0,1,0 -> out_valid pattern 1,0,1,0 delayed by 4 cycles, with correct sums.
- Reset mid-flight: accept 3 ops, assert reset asynchronously between clock edges -> out_valid, sum, cout and ovf all read 0 immediately. After release, no stale result ever appears. A new op 0x0002+0x0003 yields 0x0005 after 4 edges.
